// File: rtl/key_step_conditioner.sv
// Debounced single-step key front end: sync, debounce, one strobe per press.
// Optional auto-repeat while held: define KEY_STEP_AUTOREPEAT_EN.
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef KEY_STEP_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 25000000
  , parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic       data_in,
  output logic       step,
  output logic       step_bit,
  output logic       pressed,
  output logic [7:0] step_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] RELEASED    = 2'd0;
  localparam logic [1:0] PRESS_CHK   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] RELEASE_CHK = 2'd3;

  logic          key_q1, key_s;
  logic          data_q1, data_s;
  logic [1:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          fire;

`ifdef KEY_STEP_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX) + 1;

  logic [RW-1:0] rcnt, rcnt_d, rlast;
  logic          rpt, rpt_d;

  // First repeat waits the long delay, later ones the period
  assign rlast = rpt ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_q1  <= 1'b1;
      key_s   <= 1'b1;
      data_q1 <= 1'b0;
      data_s  <= 1'b0;
    end else begin
      key_q1  <= key_n;
      key_s   <= key_q1;
      data_q1 <= data_in;
      data_s  <= data_q1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fire    = 1'b0;
`ifdef KEY_STEP_AUTOREPEAT_EN
    rcnt_d  = rcnt;
    rpt_d   = rpt;
`endif
    unique case (1'b1)
      (state == RELEASED): begin
        if (!key_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      (state == PRESS_CHK): begin
        if (key_s) begin
          state_d = RELEASED;
        end else if (cnt == CNT_LAST) begin
          state_d = HELD;
          fire    = 1'b1;
`ifdef KEY_STEP_AUTOREPEAT_EN
          rcnt_d  = '0;
          rpt_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      (state == HELD): begin
        if (key_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
`ifdef KEY_STEP_AUTOREPEAT_EN
          rcnt_d  = '0;
          rpt_d   = 1'b0;
        end else if (rcnt == rlast) begin
          fire   = 1'b1;
          rcnt_d = '0;
          rpt_d  = 1'b1;
        end else begin
          rcnt_d = rcnt + RW'(1);
`endif
        end
      end
      default: begin
        if (!key_s) begin
          state_d = HELD;
`ifdef KEY_STEP_AUTOREPEAT_EN
          rcnt_d  = '0;
          rpt_d   = 1'b0;
`endif
        end else if (cnt == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RELEASED;
      cnt        <= '0;
      step       <= 1'b0;
      step_bit   <= 1'b0;
      step_count <= 8'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      step  <= fire;
      if (fire) begin
        step_bit   <= data_s;
        step_count <= step_count + 8'd1;
      end
    end
  end

`ifdef KEY_STEP_AUTOREPEAT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt <= '0;
      rpt  <= 1'b0;
    end else begin
      rcnt <= rcnt_d;
      rpt  <= rpt_d;
    end
  end
`endif

  assign pressed = (state == HELD) || (state == RELEASE_CHK);

endmodule
